// File: rtl/conv33_output_stage.sv
// Output stage of the 3x3 conv pipeline: tracks raster position of accepted pixels,
// keeps only fully-inside windows, shifts them and queues them in a small FIFO.
module conv33_output_stage #(
  parameter int WIDTH      = 16,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [NW-1:0]    count;
  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic             last_mem [FIFO_DEPTH];

  logic accept;
  logic pix_last;
  logic push;
  logic pop;

  // in_ready depends on registered occupancy only, never on out_ready.
  assign in_ready  = (count < DEPTH_N);
  assign accept    = in_valid && in_ready;
  assign pix_last  = (col == COL_LAST) && (row == ROW_LAST);
  assign push      = accept && (col >= CW'(2)) && (row >= RW'(2));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;
  assign out_last = out_valid && last_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && pix_last;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the data array has no reset; it is qualified by count, and leaving it
  // unreset lets it map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_sum >> SHIFT;
      last_mem[wr_ptr] <= pix_last;
    end
  end

endmodule

// File: tb/tb_conv33_output_stage.sv
// Self-checking bench for conv33_output_stage on a 4x4 image: scoreboard-based
// streaming tests plus a table-driven check of a SHIFT=3 instance.
module tb_conv33_output_stage;

  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [15:0] in_sum, out_data;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2, frame_done2;
  logic [15:0] in_sum2, out_data2;

  always #5 clk = ~clk;

  conv33_output_stage #(.WIDTH(16), .IMG_W(W), .IMG_H(H), .SHIFT(0), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done)
  );

  conv33_output_stage #(.WIDTH(16), .IMG_W(W), .IMG_H(H), .SHIFT(3), .FIFO_DEPTH(D)) dut_sh (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_sum(in_sum2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .frame_done(frame_done2)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] sum;
    logic        keep;
    logic [15:0] exp_data;
    logic        exp_last;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t q2[$];
  int   m_col = 0;
  int   m_row = 0;
  logic fd_exp = 1'b0;
  int   n_out = 0;
  int   n_last = 0;
  logic toggle = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_col  = 0;
    m_row  = 0;
    fd_exp = 1'b0;
  endtask

  // One clock cycle on the main DUT: drive, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [15:0] s, input logic r, output logic acc);
    int   size_before;
    logic fd_next;
    exp_t e;
    in_valid  = v;
    in_sum    = s;
    out_ready = r;
    #1;
    size_before = q.size();
    check("in_ready", 32'(in_ready), 32'(size_before < D));
    check("out_valid", 32'(out_valid), 32'(size_before != 0));
    check("frame_done", 32'(frame_done), 32'(fd_exp));
    if (out_valid && r) begin
      n_out++;
      if (out_last) n_last++;
    end
    if (size_before != 0) begin
      check("out_data", 32'(out_data), 32'(q[0].data));
      check("out_last", 32'(out_last), 32'(q[0].last));
      if (r) void'(q.pop_front());
    end
    acc     = v && (size_before < D);
    fd_next = acc && (m_col == W - 1) && (m_row == H - 1);
    if (acc) begin
      if (m_col >= 2 && m_row >= 2) begin
        e.data = s;
        e.last = (m_col == W - 1) && (m_row == H - 1);
        q.push_back(e);
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    fd_exp = fd_next;
    @(negedge clk);
  endtask

  // rmode: 0 = out_ready low, 1 = high, 2 = alternating each cycle. gap adds random idle cycles.
  task automatic stream(input int npix, input int rmode, input logic gap);
    logic acc;
    logic v;
    logic r;
    int   tries;
    for (int p = 0; p < npix; p++) begin
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        v = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (rmode == 2) begin
          r      = toggle;
          toggle = ~toggle;
        end else begin
          r = (rmode == 1);
        end
        cycle(v, 16'(p % (W * H)), r, acc);
        acc = acc && v;
        tries++;
      end
      if (!acc) check("accept_timeout", 32'(tries), 32'd0);
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 3 * D + 4; i++) cycle(1'b0, 16'h0, 1'b1, acc);
  endtask

  vec_t tbl[W*H];

  initial begin
    logic acc;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sum     = '0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_sum2    = '0;
    out_ready2 = 1'b0;

    for (int i = 0; i < W * H; i++) tbl[i] = '{16'hFFFF, 1'b0, 16'h0, 1'b0};
    tbl[10] = '{16'hFFF8, 1'b1, 16'h1FFF, 1'b0};
    tbl[11] = '{16'h0007, 1'b1, 16'h0000, 1'b0};
    tbl[14] = '{16'h0100, 1'b1, 16'h0020, 1'b0};
    tbl[15] = '{16'hFFFF, 1'b1, 16'h1FFF, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // SHIFT=3 instance, table-driven, out_ready held high
    out_ready2 = 1'b1;
    for (int i = 0; i < W * H + 2; i++) begin
      in_valid2 = (i < W * H);
      in_sum2   = (i < W * H) ? tbl[i].sum : 16'h0;
      #1;
      check("sh_out_valid", 32'(out_valid2), 32'(q2.size() != 0));
      check("sh_frame_done", 32'(frame_done2), 32'(i == W * H));
      if (q2.size() != 0) begin
        check("sh_out_data", 32'(out_data2), 32'(q2[0].data));
        check("sh_out_last", 32'(out_last2), 32'(q2[0].last));
        void'(q2.pop_front());
      end
      if (i < W * H && tbl[i].keep) q2.push_back('{tbl[i].exp_data, tbl[i].exp_last});
      @(negedge clk);
    end
    in_valid2 = 1'b0;

    // Mid-frame reset with two entries queued
    stream(12, 0, 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Free-flowing frame, then full-backpressure frame and drain
    stream(16, 1, 1'b0);
    drain();
    stream(16, 0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_data", 32'(out_data), 32'd10);
    drain();

    // Three back-to-back frames with alternating out_ready
    n_out  = 0;
    n_last = 0;
    stream(48, 2, 1'b0);
    drain();
    check("btb_outputs", 32'(n_out), 32'd12);
    check("btb_lasts", 32'(n_last), 32'd3);

    // Random input gaps over two frames
    n_out  = 0;
    n_last = 0;
    stream(32, 1, 1'b1);
    drain();
    check("gap_outputs", 32'(n_out), 32'd8);
    check("gap_lasts", 32'(n_last), 32'd2);

    cycle(1'b0, 16'h0, 1'b0, acc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

endmodule
